// File: rtl/score_display_ctrl_if.sv
// Link between the score controller and the shared seven-segment renderer:
// the controller drives a digit origin and value, the renderer answers seg_hit in the same cycle.
interface score_display_ctrl_if;
   logic [9:0] segx;
   logic [9:0] segy;
   logic [3:0] num;
   logic       seg_hit;

   modport master (output segx, segy, num, input seg_hit);
   modport slave  (input segx, segy, num, output seg_hit);
endinterface

// File: rtl/score_display_ctrl.sv
// Goose-run HUD score controller: BCD run score and high score, IDLE/RUN/OVER phase FSM,
// and digit steering of a single shared seven-segment renderer from the VGA pixel position.
module score_display_ctrl #(
   parameter int ORIGIN_X = 560,
   parameter int ORIGIN_Y = 16,
   parameter int PITCH    = 12,
   parameter int DIG_W    = 10,
   parameter int DIG_H    = 20
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        tick,
   input  logic [9:0]                  x,
   input  logic [9:0]                  y,
   input  logic                        video_on,
   input  logic                        score_inc,
   input  logic                        game_start,
   input  logic                        game_over,
   score_display_ctrl_if.master        rend,
   output logic                        pix_on,
   output logic [15:0]                 score_bcd,
   output logic [15:0]                 hi_bcd,
   output logic                        overflow,
   output logic [1:0]                  state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   // Game events are single-cycle level pulses sampled on every rising edge; there is
   // no ready/back-pressure, and a pulse held for N cycles acts N times.

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         score_bcd <= 16'h0000;
         hi_bcd    <= 16'h0000;
         overflow  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (game_start) begin
                  state     <= ST_RUN;
                  score_bcd <= 16'h0000;
                  overflow  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (score_inc) begin
                  if (score_bcd == 16'h9999) overflow <= 1'b1;
                  else                       score_bcd <= bcd_inc(score_bcd);
               end
               if (game_over) state <= ST_OVER;
            end
            ST_OVER: begin
               // Score is frozen in OVER, so comparing every OVER cycle equals comparing once.
               if (score_bcd > hi_bcd) hi_bcd <= score_bcd;
               if (game_start) begin
                  state     <= ST_RUN;
                  score_bcd <= 16'h0000;
                  overflow  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic [15:0] disp;
   logic [3:0]  blank;
   logic        in_box;
   logic        blank_sel;

   assign disp = (state == ST_IDLE) ? hi_bcd : score_bcd;

   // Leading-zero blanking; the least significant digit always shows.
   always_comb begin
      blank    = 4'b0000;
      blank[0] = (disp[15:12] == 4'd0);
      blank[1] = blank[0] & (disp[11:8] == 4'd0);
      blank[2] = blank[1] & (disp[7:4] == 4'd0);
   end

   always_comb begin
      rend.segx = 10'(ORIGIN_X);
      rend.segy = 10'(ORIGIN_Y);
      rend.num  = 4'd0;
      in_box    = 1'b0;
      blank_sel = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (x >= 10'(ORIGIN_X + k*PITCH) && x <= 10'(ORIGIN_X + k*PITCH + DIG_W - 1) &&
             y >= 10'(ORIGIN_Y) && y <= 10'(ORIGIN_Y + DIG_H - 1)) begin
            rend.segx = 10'(ORIGIN_X + k*PITCH);
            rend.num  = disp[4*(3-k) +: 4];
            in_box    = 1'b1;
            blank_sel = blank[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pix_on <= 1'b0;
      else if (tick) pix_on <= video_on & in_box & ~blank_sel & rend.seg_hit;
   end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: scoring, saturation, high score, digit steering and blanking.
module tb_score_display_ctrl;

   logic        clk;
   logic        rst_n;
   logic        tick;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        video_on;
   logic        score_inc;
   logic        game_start;
   logic        game_over;
   logic        pix_on;
   logic [15:0] score_bcd;
   logic [15:0] hi_bcd;
   logic        overflow;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   score_display_ctrl_if rif ();

   score_display_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .x          (x),
      .y          (y),
      .video_on   (video_on),
      .score_inc  (score_inc),
      .game_start (game_start),
      .game_over  (game_over),
      .rend       (rif),
      .pix_on     (pix_on),
      .score_bcd  (score_bcd),
      .hi_bcd     (hi_bcd),
      .overflow   (overflow),
      .state      (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drivers: all called at a falling edge and return at a falling edge
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      game_start = 1'b1;
      @(negedge clk);
      game_start = 1'b0;
   endtask

   task automatic pulse_over();
      game_over = 1'b1;
      @(negedge clk);
      game_over = 1'b0;
   endtask

   task automatic do_inc(input int n);
      score_inc = 1'b1;
      repeat (n) @(negedge clk);
      score_inc = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (state !== 2'd0)         begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_score: got %h want 0000", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0000)    begin n_bad++; $display("FAIL reset_hi: got %h want 0000", hi_bcd); end
      n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      n_cmp++; if (pix_on !== 1'b0)        begin n_bad++; $display("FAIL reset_pix: got %b want 0", pix_on); end
      // events that must be ignored in IDLE
      do_inc(3);
      pulse_over();
      n_cmp++; if (state !== 2'd0)         begin n_bad++; $display("FAIL idle_ignore_state: got %0d want 0", state); end
      n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL idle_ignore_inc: got %h want 0000", score_bcd); end
   endtask

   task automatic test_count();
      do_reset();
      pulse_start();
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_state: got %0d want 1", state); end
      do_inc(1234);
      n_cmp++; if (score_bcd !== 16'h1234) begin n_bad++; $display("FAIL count_1234: got %h want 1234", score_bcd); end
      n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL count_ovf: got %b want 0", overflow); end
      pulse_start();
      n_cmp++; if (score_bcd !== 16'h1234) begin n_bad++; $display("FAIL run_ignore_start: got %h want 1234", score_bcd); end
   endtask

   task automatic test_carry();
      do_reset();
      pulse_start();
      do_inc(99);
      n_cmp++; if (score_bcd !== 16'h0099) begin n_bad++; $display("FAIL carry_0099: got %h want 0099", score_bcd); end
      do_inc(1);
      n_cmp++; if (score_bcd !== 16'h0100) begin n_bad++; $display("FAIL carry_0100: got %h want 0100", score_bcd); end
      do_inc(900);
      n_cmp++; if (score_bcd !== 16'h1000) begin n_bad++; $display("FAIL carry_1000: got %h want 1000", score_bcd); end
   endtask

   task automatic test_saturate();
      do_reset();
      pulse_start();
      do_inc(9999);
      n_cmp++; if (score_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_9999: got %h want 9999", score_bcd); end
      n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL sat_ovf_early: got %b want 0", overflow); end
      do_inc(2);
      n_cmp++; if (score_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_hold: got %h want 9999", score_bcd); end
      n_cmp++; if (overflow !== 1'b1)      begin n_bad++; $display("FAIL sat_ovf: got %b want 1", overflow); end
      pulse_over();
      @(negedge clk);
      n_cmp++; if (hi_bcd !== 16'h9999)    begin n_bad++; $display("FAIL sat_hi: got %h want 9999", hi_bcd); end
      pulse_start();
      n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL restart_score: got %h want 0000", score_bcd); end
      n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL restart_ovf: got %b want 0", overflow); end
      n_cmp++; if (state !== 2'd1)         begin n_bad++; $display("FAIL restart_state: got %0d want 1", state); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      pulse_start();
      do_inc(42);
      score_inc = 1'b1;
      game_over = 1'b1;
      @(negedge clk);
      score_inc = 1'b0;
      game_over = 1'b0;
      n_cmp++; if (state !== 2'd2)         begin n_bad++; $display("FAIL same_state: got %0d want 2", state); end
      n_cmp++; if (score_bcd !== 16'h0043) begin n_bad++; $display("FAIL same_score: got %h want 0043", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0000)    begin n_bad++; $display("FAIL hi_one_edge: got %h want 0000", hi_bcd); end
      @(negedge clk);
      n_cmp++; if (hi_bcd !== 16'h0043)    begin n_bad++; $display("FAIL hi_two_edges: got %h want 0043", hi_bcd); end
      do_inc(5);
      n_cmp++; if (score_bcd !== 16'h0043) begin n_bad++; $display("FAIL over_ignore_inc: got %h want 0043", score_bcd); end
      pulse_start();
      do_inc(10);
      pulse_over();
      repeat (2) @(negedge clk);
      n_cmp++; if (score_bcd !== 16'h0010) begin n_bad++; $display("FAIL second_score: got %h want 0010", score_bcd); end
      n_cmp++; if (hi_bcd !== 16'h0043)    begin n_bad++; $display("FAIL second_hi: got %h want 0043", hi_bcd); end
   endtask

   task automatic test_display();
      do_reset();
      // IDLE shows hi score 0000 as a single '0' in digit 3
      x = 10'd600; y = 10'd26; video_on = 1'b1; tick = 1'b1; rif.seg_hit = 1'b1;
      #1;
      n_cmp++; if (rif.num !== 4'd0) begin n_bad++; $display("FAIL idle_num: got %0d want 0", rif.num); end
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b1)  begin n_bad++; $display("FAIL idle_zero_pix: got %b want 1", pix_on); end
      rif.seg_hit = 1'b0;
      pulse_start();
      do_inc(7);
      rif.seg_hit = 1'b1;
      #1;
      n_cmp++; if (rif.segx !== 10'd596) begin n_bad++; $display("FAIL d3_segx: got %0d want 596", rif.segx); end
      n_cmp++; if (rif.segy !== 10'd16)  begin n_bad++; $display("FAIL d3_segy: got %0d want 16", rif.segy); end
      n_cmp++; if (rif.num !== 4'd7)     begin n_bad++; $display("FAIL d3_num: got %0d want 7", rif.num); end
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b1) begin n_bad++; $display("FAIL d3_pix_hit: got %b want 1", pix_on); end
      rif.seg_hit = 1'b0;
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b0) begin n_bad++; $display("FAIL d3_pix_miss: got %b want 0", pix_on); end
      tick = 1'b0; rif.seg_hit = 1'b1;
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b0) begin n_bad++; $display("FAIL tick_hold: got %b want 0", pix_on); end
      tick = 1'b1;
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b1) begin n_bad++; $display("FAIL tick_capture: got %b want 1", pix_on); end
      // digit 0 is a leading zero
      x = 10'd565;
      #1;
      n_cmp++; if (rif.segx !== 10'd560) begin n_bad++; $display("FAIL d0_segx: got %0d want 560", rif.segx); end
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b0) begin n_bad++; $display("FAIL d0_blank: got %b want 0", pix_on); end
      x = 10'd586;
      #1;
      n_cmp++; if (rif.segx !== 10'd584) begin n_bad++; $display("FAIL d2_segx: got %0d want 584", rif.segx); end
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b0) begin n_bad++; $display("FAIL d2_blank: got %b want 0", pix_on); end
      // just past digit 3's right edge
      x = 10'd606;
      #1;
      n_cmp++; if (rif.segx !== 10'd560) begin n_bad++; $display("FAIL right_out_segx: got %0d want 560", rif.segx); end
      n_cmp++; if (rif.num !== 4'd0)     begin n_bad++; $display("FAIL right_out_num: got %0d want 0", rif.num); end
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b0) begin n_bad++; $display("FAIL right_out_pix: got %b want 0", pix_on); end
      // gap column between digits 1 and 2
      x = 10'd583;
      #1;
      n_cmp++; if (rif.segx !== 10'd560) begin n_bad++; $display("FAIL gap_segx: got %0d want 560", rif.segx); end
      // bottom row boundary of digit 3
      x = 10'd600; y = 10'd35;
      #1;
      n_cmp++; if (rif.num !== 4'd7) begin n_bad++; $display("FAIL bottom_in_num: got %0d want 7", rif.num); end
      y = 10'd36;
      #1;
      n_cmp++; if (rif.segx !== 10'd560) begin n_bad++; $display("FAIL bottom_out_segx: got %0d want 560", rif.segx); end
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b0) begin n_bad++; $display("FAIL bottom_out_pix: got %b want 0", pix_on); end
      y = 10'd26; video_on = 1'b0;
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b0) begin n_bad++; $display("FAIL video_off_pix: got %b want 0", pix_on); end
      video_on = 1'b1;
      @(negedge clk);
      n_cmp++; if (pix_on !== 1'b1) begin n_bad++; $display("FAIL video_on_pix: got %b want 1", pix_on); end
      // asynchronous reset in the middle of a cycle
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL async_score: got %h want 0000", score_bcd); end
      n_cmp++; if (state !== 2'd0)         begin n_bad++; $display("FAIL async_state: got %0d want 0", state); end
      n_cmp++; if (pix_on !== 1'b0)        begin n_bad++; $display("FAIL async_pix: got %b want 0", pix_on); end
      @(negedge clk);
      rst_n = 1'b1;
      rif.seg_hit = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; x = 10'd0; y = 10'd0; video_on = 1'b0;
      score_inc = 1'b0; game_start = 1'b0; game_over = 1'b0; rif.seg_hit = 1'b0;
      @(negedge clk);
      test_reset();
      test_count();
      test_carry();
      test_saturate();
      test_same_cycle();
      test_display();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
